// File: rtl/vga_image_reader_if.sv
// Read-only image memory port between the VGA reader (master) and the image RAM (slave).
// The RAM returns mem_rdata one clk after a cycle with mem_rd_en high; there is no backpressure.
interface vga_image_reader_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rdata;

    modport master (output mem_addr, output mem_rd_en, input mem_rdata);
    modport slave  (input mem_addr, input mem_rd_en, output mem_rdata);
endinterface

// File: rtl/vga_image_reader.sv
// VGA timing generator and grayscale image streamer for a synchronous-read image memory.
// Pixel rate is clk/2; the image sits top-left and is gated per frame by `show`.
module vga_image_reader #(
    parameter int                IMG_W     = 256,
    parameter int                IMG_H     = 256,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                H_VIS     = 640,
    parameter int                H_FP      = 16,
    parameter int                H_SYNC    = 96,
    parameter int                H_BP      = 48,
    parameter int                V_VIS     = 480,
    parameter int                V_FP      = 10,
    parameter int                V_SYNC    = 2,
    parameter int                V_BP      = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       show,
    vga_image_reader_if.master         mem,
    output logic                       vga_clk,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       blank_n,
    output logic                       sync_n,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [HW-1:0] IMG_W_C  = HW'(IMG_W);
    localparam logic [VW-1:0] IMG_H_C  = VW'(IMG_H);
    localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

    logic          pix_en;
    logic [HW-1:0] h, h_nxt;
    logic [VW-1:0] v, v_nxt;
    logic          frame_on, frame_on_nxt;
    logic          frame_wrap;
    logic          visible, in_img, in_img_nxt;
    logic          hs_act, vs_act;
    logic [7:0]    pix;

    always_comb begin
        frame_wrap   = (h == H_LAST) && (v == V_LAST);
        h_nxt        = (h == H_LAST) ? '0 : h + 1'b1;
        v_nxt        = v;
        if (h == H_LAST) begin
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
        // show is only looked at as a new frame begins, so a frame is never torn
        frame_on_nxt = frame_wrap ? show : frame_on;
        visible      = (h < H_VIS_C) && (v < V_VIS_C);
        in_img       = frame_on && (h < IMG_W_C) && (v < IMG_H_C);
        in_img_nxt   = frame_on_nxt && (h_nxt < IMG_W_C) && (v_nxt < IMG_H_C);
        hs_act       = (h >= HS_START) && (h < HS_END);
        vs_act       = (v >= VS_START) && (v < VS_END);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_en        <= 1'b0;
            vga_clk       <= 1'b0;
            h             <= '0;
            v             <= '0;
            frame_on      <= 1'b0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            blank_n       <= 1'b0;
            pix           <= 8'h00;
            mem.mem_rd_en <= 1'b0;
            mem.mem_addr  <= BASE_ADDR;
        end else begin
            pix_en        <= ~pix_en;
            vga_clk       <= pix_en;
            mem.mem_rd_en <= 1'b0;
            if (pix_en) begin
                h        <= h_nxt;
                v        <= v_nxt;
                frame_on <= frame_on_nxt;
                // outputs describe the pixel being left; its read data arrived this cycle
                hsync    <= ~hs_act;
                vsync    <= ~vs_act;
                blank_n  <= visible;
                pix      <= in_img ? mem.mem_rdata : 8'h00;
                // image pixels are visited in raster order, so a running pointer replaces v*IMG_W+h
                mem.mem_rd_en <= in_img_nxt;
                if (frame_wrap) begin
                    mem.mem_addr <= BASE_ADDR;
                end else if (in_img_nxt) begin
                    mem.mem_addr <= mem.mem_addr + 1'b1;
                end
            end
        end
    end

    assign sync_n = 1'b0;
    assign r      = pix;
    assign g      = pix;
    assign b      = pix;
endmodule

// File: tb/tb_vga_image_reader.sv
// Bench for vga_image_reader using a shrunken raster so several frames fit in a short run.
// Expected pixels come from a raster/time model of the display, not from the DUT.
module tb_vga_image_reader;
    localparam int IW  = 8;
    localparam int IH  = 6;
    localparam int HV  = 24;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 2;
    localparam int VV  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FP  = HT * VT;
    localparam logic [23:0] BASE = 24'h000010;
    localparam int BUDGET = 3 * FP * 2 + 100;

    typedef struct {
        int          f;
        int          h;
        int          v;
        logic [10:0] e;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        show  = 1'b1;
    logic        vga_clk, hsync, vsync, blank_n, sync_n;
    logic [7:0]  r, g, b;

    int          checks = 0;
    int          errors = 0;
    int          ecnt   = 0;
    int          shown[0:15];
    logic [10:0] exp_q[$];
    vec_t        vecs[$];
    logic [10:0] m_e;
    logic        m_rd;
    logic [23:0] m_a;

    vga_image_reader_if #(.ADDR_W(24)) mem_bus ();

    vga_image_reader #(
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(24), .BASE_ADDR(BASE),
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .show(show), .mem(mem_bus),
        .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .sync_n(sync_n), .r(r), .g(g), .b(b)
    );

    // clock / reset
    always #10 clk = ~clk;

    // image memory: data = low address byte, junk when no read was issued
    always @(posedge clk) begin
        mem_bus.mem_rdata <= mem_bus.mem_rd_en ? mem_bus.mem_addr[7:0] : 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ecnt=%0d got=%0h want=%0h", name, ecnt, act, exp);
        end
    endtask

    // expected {hsync, vsync, blank_n, gray}, read strobe and address for pixel p since release
    function automatic void model(input int p, output logic [10:0] e, output logic rd,
                                  output logic [23:0] a);
        int h, v, f;
        logic vis, img;
        h   = p % HT;
        v   = (p / HT) % VT;
        f   = p / FP;
        vis = (h < HV) && (v < VV);
        img = (f < 16) && (shown[f] != 0) && (h < IW) && (v < IH);
        a   = BASE + 24'(v * IW + h);
        e   = {!(h >= HV + HFP && h < HV + HFP + HS), !(v >= VV + VFP && v < VV + VFP + VS),
               vis, img ? a[7:0] : 8'h00};
        rd  = img;
    endfunction

    // scoreboard producer: edge count since release, frame gating, expected pixel per pixel period
    always @(posedge clk) begin
        if (!reset) begin
            ecnt = 0;
            exp_q.delete();
            foreach (shown[i]) shown[i] = 0;
        end else begin
            ecnt++;
            if (ecnt % 2 == 0 && (ecnt / 2) % FP == 0 && (ecnt / 2) / FP < 16)
                shown[(ecnt / 2) / FP] = int'(show);
            if (ecnt % 2 == 1) begin
                model((ecnt - 1) / 2, m_e, m_rd, m_a);
                exp_q.push_back(m_e);
            end
        end
    end

    // scoreboard consumer
    always @(negedge clk) begin
        logic [10:0] e;
        logic        rd;
        logic [23:0] a;
        if (reset && ecnt > 0) begin
            check("vga_clk", 32'(vga_clk), 32'(ecnt % 2 == 0));
            if (ecnt % 2 == 0) begin
                if (exp_q.size() == 0) begin
                    check("pix_q_empty", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pix", 32'({hsync, vsync, blank_n, r, g, b}), 32'({e, e[7:0], e[7:0]}));
                end
                check("sync_n", 32'(sync_n), 32'(0));
                model(ecnt / 2, e, rd, a);
                check("rd_en", 32'(mem_bus.mem_rd_en), 32'(rd));
                if (rd) check("rd_addr", 32'(mem_bus.mem_addr), 32'(a));
            end else begin
                check("rd_en_odd", 32'(mem_bus.mem_rd_en), 32'(0));
            end
        end
    end

    // wait until the outputs show pixel p (counted from release)
    task automatic wait_pix(input int p, output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ecnt >= 2 && ecnt % 2 == 0 && ecnt / 2 - 1 == p) && n < BUDGET);
        ok = (n < BUDGET);
        if (!ok) check("wait_pix_timeout", 32'(p), 32'(ecnt / 2 - 1));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_vga_clk"}, 32'(vga_clk), 32'(0));
        check({tag, "_sync"}, 32'({hsync, vsync}), 32'(2'b11));
        check({tag, "_blank_n"}, 32'(blank_n), 32'(0));
        check({tag, "_rgb"}, 32'({r, g, b}), 32'(0));
        check({tag, "_rd_en"}, 32'(mem_bus.mem_rd_en), 32'(0));
        check({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'(BASE));
    endtask

    function automatic logic sig(input bit vert);
        return vert ? vsync : hsync;
    endfunction

    // low width and period of a sync line, in clk
    task automatic measure(input bit vert, output int low_w, output int per);
        int n;
        n = 0; low_w = 0; per = 0;
        while (sig(vert) == 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
        while (sig(vert) == 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
        while (sig(vert) == 1'b0 && n < BUDGET) begin @(negedge clk); n++; low_w++; end
        per = low_w;
        while (sig(vert) == 1'b1 && n < BUDGET) begin @(negedge clk); n++; per++; end
    endtask

    task automatic probe(input string name, input int p, input logic [10:0] e);
        bit ok;
        wait_pix(p, ok);
        if (ok) check(name, 32'({hsync, vsync, blank_n, r}), 32'(e));
    endtask

    initial begin
        int lw, pr, tgt;
        bit ok;

        // {frame, h, v, {hsync, vsync, blank_n, gray}}; frame 0 black, 1 image, 2 black, 3 image
        vecs.push_back('{0,  0,  0, 11'h700});
        vecs.push_back('{0,  2,  3, 11'h700});
        vecs.push_back('{1,  0,  0, 11'h710});
        vecs.push_back('{1,  5,  0, 11'h715});
        vecs.push_back('{1,  8,  0, 11'h700});
        vecs.push_back('{1, 24,  0, 11'h600});
        vecs.push_back('{1, 26,  0, 11'h200});
        vecs.push_back('{1, 29,  0, 11'h200});
        vecs.push_back('{1, 30,  0, 11'h600});
        vecs.push_back('{1,  0,  1, 11'h718});
        vecs.push_back('{1,  7,  5, 11'h73F});
        vecs.push_back('{1,  0,  6, 11'h700});
        vecs.push_back('{1, 23, 11, 11'h700});
        vecs.push_back('{1,  0, 12, 11'h600});
        vecs.push_back('{1,  0, 14, 11'h400});
        vecs.push_back('{1, 31, 15, 11'h400});
        vecs.push_back('{1,  0, 16, 11'h600});
        vecs.push_back('{2,  3,  1, 11'h700});
        vecs.push_back('{2,  7,  5, 11'h700});
        vecs.push_back('{3,  0,  0, 11'h710});
        vecs.push_back('{3,  1,  2, 11'h721});

        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        reset = 1'b1;

        fork
            begin
                bit ok1;
                wait_pix(FP + 3 * HT, ok1);
                show = 1'b0;
                wait_pix(2 * FP + 5 * HT, ok1);
                show = 1'b1;
            end
            begin
                bit ok2;
                for (int i = 0; i < vecs.size(); i++) begin
                    wait_pix(vecs[i].f * FP + vecs[i].v * HT + vecs[i].h, ok2);
                    if (ok2) check($sformatf("vec%0d", i), 32'({hsync, vsync, blank_n, r}),
                                   32'(vecs[i].e));
                end
            end
        join

        measure(1'b0, lw, pr);
        check("hsync_low", 32'(lw), 32'(HS * 2));
        check("hsync_period", 32'(pr), 32'(HT * 2));
        measure(1'b1, lw, pr);
        check("vsync_low", 32'(lw), 32'(VS * HT * 2));
        check("vsync_period", 32'(pr), 32'(FP * 2));

        // reset in the middle of an image frame, then timing restarts with the image gated off
        tgt = ((ecnt / 2) / FP + 1) * FP + 3 * HT + 10;
        wait_pix(tgt, ok);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("midrst");
        reset = 1'b1;
        wait_pix(0, ok);
        if (ok) check("after_rst_addr", 32'(mem_bus.mem_addr), 32'(BASE));
        if (ok) check("after_rst_pix0", 32'({hsync, vsync, blank_n, r}), 32'(11'h700));
        probe("after_rst_black", 3 * HT + 2, 11'h700);
        probe("after_rst_first", FP, 11'h710);
        probe("after_rst_img", FP + 2 * HT + 3, 11'h723);
        probe("after_rst_edge", FP + 5 * HT + 7, 11'h73F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_image_reader.md
Name: vga_image_reader

Overview:
Read-side consumer of the image memory written by the single-cycle processor. Generates 640x480@60 VGA timing from the system clock and streams an IMG_W x IMG_H 8-bit grayscale image out of a synchronous-read image memory. The image occupies the top-left of the visible area; all other visible pixels are black. Display is gated by the processor's `vga` show flag, which is sampled only at frame boundaries so the picture never tears.

Parameters:
IMG_W, 256, image width in pixels (1..640)
IMG_H, 256, image height in lines (1..480)
BASE_ADDR, 24'h000000, memory address of pixel (0,0); row-major, 1 byte per address
ADDR_W, 24, memory address width

Ports:
clk  in  1  system clock (50 MHz); pixel rate is clk/2
reset  in  1  synchronous active-low reset (reset==0 resets on the clk edge)
show  in  1  display enable, driven by the processor's `vga` flip-flop
mem_rdata  in  8  image memory read data, valid 1 clk after mem_addr/mem_rd_en
mem_addr  out  ADDR_W  image memory read address
mem_rd_en  out  1  read strobe, 1 clk wide
vga_clk  out  1  pixel clock to DAC, clk/2
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
blank_n  out  1  high during the visible 640x480 area
sync_n  out  1  tied low (no sync-on-green)
r  out  8  red
g  out  8  green
b  out  8  blue; r = g = b = grayscale value

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - pix_en=0, vga_clk=0, h=0, v=0, frame_on=0
  - hsync=1, vsync=1, blank_n=0, r=g=b=0
  - mem_rd_en=0, mem_addr=BASE_ADDR
  - Reset mid-frame restarts timing at (0,0) on the next edge.
- pix_en toggles every clk. vga_clk = registered pix_en.
- Counters advance only on clk edges where pix_en==1:
  - h runs 0..799 and wraps to 0.
  - v increments when h wraps; v runs 0..524 and wraps to 0.
- Timing per (h,v):
  - visible = (h<640) && (v<480)
  - hsync low for 656<=h<=751
  - vsync low for 490<=v<=491
- Frame gating: frame_on <= show, sampled only on the pix_en edge where h wraps 799->0 and v wraps 524->0. A change of `show` mid-frame has no effect until the next frame.
- in_img = frame_on && (h<IMG_W) && (v<IMG_H).
- Address generation:
  - Running pointer; no multiplier. Reset to BASE_ADDR at frame start (h=0,v=0).
  - On the pix_en==0 cycle preceding a pixel with in_img: mem_addr = pointer, mem_rd_en=1 for that clk, pointer increments on the following pix_en edge.
  - mem_rd_en=0 when not in_img. mem_addr holds its last value.
  - Last image pixel reads BASE_ADDR + IMG_W*IMG_H - 1. The pointer never exceeds this within a frame.
- Output pipeline:
  - r/g/b, hsync, vsync, blank_n are registered on the same pix_en edge, so all describe the same (h,v). Fixed latency: 1 pixel period (2 clk) from the counter value to the outputs.
  - Pixel value: in_img -> mem_rdata; visible && !in_img -> 0; !visible -> 0 with blank_n=0.
- Simultaneous events:
  - show changing on the same edge as the frame wrap: the new value is taken.
  - Reset has priority over everything.
- Read-only toward memory: never drives write enable or data. No backpressure; memory must return data in 1 clk.

Test Plan:
1. Reset then release -> outputs hold reset values during reset. After release, hsync period = 1600 clk with a low pulse of 192 clk; vsync period = 525 lines with a low pulse of 2 lines.
2. show=1 before frame start, memory model returns data=addr[7:0] -> pixel (0,0) r=g=b=0x00, pixel (5,0)=0x05, pixel (0,1)=IMG_W[7:0], last pixel address = 0x00FFFF. Outputs align with blank_n=1.
3. show=0 for a whole frame -> mem_rd_en never asserts, r=g=b=0 throughout, sync timing unchanged.
4. show 0->1 at line 100 -> current frame stays black; next frame displays the image starting at BASE_ADDR.
5. Pixels at h>=IMG_W or v>=IMG_H within the visible area -> r=g=b=0, blank_n=1, no read strobes. The blanking region gives blank_n=0 and rgb=0.
6. Reset asserted at (h=300,v=200) for 3 clk -> the next frame starts at (0,0) with mem_addr=BASE_ADDR and frame_on=0 until the first frame boundary.
